// File: rtl/v_instr_issuer.sv
// Vector instruction issuer: encodes symbolic requests into RVV 1.0 words, queues them,
// and presents one word at a time to the coprocessor until its completion strobe returns.
module v_instr_issuer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [1:0]  req_form,
  input  logic [4:0]  req_vd,
  input  logic [4:0]  req_src1,
  input  logic [4:0]  req_src2,
  input  logic [10:0] req_zimm,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        v_reg_wr_en,
  input  logic        x_reg_wr_en,
  input  logic        s_done,
  output logic        illegal,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OPC_RTYPE = 7'b1010111;
  localparam logic [6:0]  OPC_LTYPE = 7'b0000111;
  localparam logic [6:0]  OPC_STYPE = 7'b0100111;
  localparam logic [2:0]  OPI_VV    = 3'b000;
  localparam logic [2:0]  OPM_VV    = 3'b010;
  localparam logic [2:0]  OPI_VI    = 3'b011;
  localparam logic [2:0]  OPI_VX    = 3'b100;
  localparam logic [2:0]  OPM_VX    = 3'b110;
  localparam logic [2:0]  OP_SET    = 3'b111;
  localparam logic [5:0]  F6_VADD   = 6'b000000;
  localparam logic [5:0]  F6_VSUB   = 6'b000010;
  localparam logic [5:0]  F6_VAND   = 6'b001001;
  localparam logic [5:0]  F6_VOR    = 6'b001010;
  localparam logic [5:0]  F6_VXOR   = 6'b001011;
  localparam logic [5:0]  F6_VSLL   = 6'b100101;
  localparam logic [5:0]  F6_VSRL   = 6'b101000;
  localparam logic [5:0]  F6_VSRA   = 6'b101001;
  localparam logic [5:0]  F6_VMIN   = 6'b000101;
  localparam logic [5:0]  F6_VMAX   = 6'b000111;
  localparam logic [5:0]  F6_VMUL   = 6'b100101;
  localparam logic [5:0]  F6_VREDSUM = 6'b000000;
  localparam logic [5:0]  F6_VREDMAX = 6'b000111;
  localparam logic [5:0]  F6_VSLIDEUP = 6'b001110;
  localparam logic [5:0]  F6_VSLIDEDN = 6'b001111;
  localparam logic [5:0]  F6_VMOVE  = 6'b010111;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] count_r;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [31:0]   mem_r [DEPTH];
  logic [31:0]   instr_r;
  logic          instr_valid_r, illegal_r;

  logic [5:0]  f6_s;
  logic [2:0]  f3_s, width_s;
  logic        ok_s, strided_s, store_s;
  logic [31:0] word_s, head_s;
  logic        handshake_s, push_s, pop_s, done_s;

  // funct6 selection by operation
  always_comb begin
    f6_s = 6'b000000;
    case (req_op)
      5'd0:  f6_s = F6_VADD;
      5'd1:  f6_s = F6_VSUB;
      5'd2:  f6_s = F6_VAND;
      5'd3:  f6_s = F6_VOR;
      5'd4:  f6_s = F6_VXOR;
      5'd5:  f6_s = F6_VSLL;
      5'd6:  f6_s = F6_VSRL;
      5'd7:  f6_s = F6_VSRA;
      5'd8:  f6_s = F6_VMIN;
      5'd9:  f6_s = F6_VMAX;
      5'd10: f6_s = F6_VMUL;
      5'd11: f6_s = F6_VREDSUM;
      5'd12: f6_s = F6_VREDMAX;
      5'd13: f6_s = F6_VSLIDEUP;
      5'd14: f6_s = F6_VSLIDEDN;
      5'd15: f6_s = F6_VSLIDEUP;
      5'd16: f6_s = F6_VSLIDEDN;
      5'd17: f6_s = F6_VMOVE;
      default: f6_s = 6'b000000;
    endcase
  end

  // funct3 / memory width and legality of the op/form combination
  always_comb begin
    f3_s    = OPI_VV;
    width_s = 3'b000;
    ok_s    = 1'b1;
    case (req_op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9: begin
        case (req_form)
          2'd0: f3_s = OPI_VV;
          2'd1: f3_s = OPI_VX;
          2'd2: f3_s = OPI_VI;
          default: ok_s = 1'b0;
        endcase
      end
      5'd10, 5'd17: begin
        case (req_form)
          2'd0: f3_s = OPM_VV;
          2'd1: f3_s = OPM_VX;
          default: ok_s = 1'b0;
        endcase
      end
      5'd11, 5'd12: begin
        if (req_form == 2'd0) f3_s = OPM_VV;
        else ok_s = 1'b0;
      end
      5'd13, 5'd14: begin
        case (req_form)
          2'd1: f3_s = OPI_VX;
          2'd2: f3_s = OPI_VI;
          default: ok_s = 1'b0;
        endcase
      end
      5'd15, 5'd16: begin
        if (req_form == 2'd1) f3_s = OPM_VX;
        else ok_s = 1'b0;
      end
      5'd18: begin
        if (req_form == 2'd3) ok_s = 1'b0;
        else f3_s = OP_SET;
      end
      5'd19, 5'd20, 5'd21, 5'd22: begin
        case (req_form)
          2'd0: width_s = 3'b000;
          2'd1: width_s = 3'b101;
          2'd2: width_s = 3'b110;
          default: ok_s = 1'b0;
        endcase
      end
      default: ok_s = 1'b0;
    endcase
  end

  // Final word assembly; unit-stride memory ops force the rs2 field to zero
  always_comb begin
    strided_s = (req_op == 5'd20) || (req_op == 5'd22);
    store_s   = (req_op == 5'd21) || (req_op == 5'd22);
    word_s    = NOP;
    if (req_op == 5'd18) begin
      word_s = {1'b0, req_zimm, req_src1, OP_SET, req_vd, OPC_RTYPE};
    end else if ((req_op >= 5'd19) && (req_op <= 5'd22)) begin
      word_s = {3'b000, 1'b0, (strided_s ? 2'b10 : 2'b00), 1'b1,
                (strided_s ? req_src2 : 5'd0), req_src1, width_s, req_vd,
                (store_s ? OPC_STYPE : OPC_LTYPE)};
    end else begin
      word_s = {f6_s, 1'b1, req_src2, req_src1, f3_s, req_vd, OPC_RTYPE};
    end
  end

  // Completion strobe is chosen by the class of the word at the FIFO head
  always_comb begin
    head_s = mem_r[rd_ptr_r];
    if (head_s[6:0] == OPC_STYPE) begin
      done_s = s_done;
    end else if ((head_s[6:0] == OPC_RTYPE) && (head_s[14:12] == OP_SET)) begin
      done_s = x_reg_wr_en;
    end else begin
      done_s = v_reg_wr_en;
    end
  end

  assign req_ready   = (count_r != FULL_CNT);
  assign handshake_s = req_valid && req_ready;
  assign push_s      = handshake_s && ok_s;

  // Issue FSM next-state and pop decision
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != {CW{1'b0}}) state_nxt_s = ISSUE;
        else state_nxt_s = IDLE;
      end
      ISSUE, WAIT: begin
        if (done_s) begin
          pop_s       = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= word_s;
  end

  // State, FIFO bookkeeping and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r       <= IDLE;
      count_r       <= {CW{1'b0}};
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      instr_r       <= NOP;
      instr_valid_r <= 1'b0;
      illegal_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      instr_r       <= (state_nxt_s == IDLE) ? NOP : head_s;
      instr_valid_r <= (state_nxt_s == ISSUE);
      illegal_r     <= handshake_s && !ok_s;
    end
  end

  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign illegal     = illegal_r;
  assign busy        = (state_r != IDLE) || (count_r != {CW{1'b0}});

endmodule
